// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the four-stage ALU pipeline: function codes,
// the per-stage instruction record and the shift-amount width helper.
package alu_pipe_pkg;

    localparam logic [3:0] FN_ADD     = 4'd0;
    localparam logic [3:0] FN_SUB     = 4'd1;
    localparam logic [3:0] FN_MUL     = 4'd2;
    localparam logic [3:0] FN_PASSA   = 4'd3;
    localparam logic [3:0] FN_PASSB   = 4'd4;
    localparam logic [3:0] FN_AND     = 4'd5;
    localparam logic [3:0] FN_OR      = 4'd6;
    localparam logic [3:0] FN_XOR     = 4'd7;
    localparam logic [3:0] FN_NEGA    = 4'd8;
    localparam logic [3:0] FN_NEGB    = 4'd9;
    localparam logic [3:0] FN_SRL1    = 4'd10;
    localparam logic [3:0] FN_SHL1    = 4'd11;
    localparam logic [3:0] FN_SRA1    = 4'd12;
    localparam logic [3:0] FN_SHL     = 4'd13;
    localparam logic [3:0] FN_SHR     = 4'd14;
    localparam logic [3:0] FN_ILLEGAL = 4'd15;

    // Record fields are sized for the largest supported configuration;
    // narrower instances zero-extend into them and the unused bits fold away.
    localparam int unsigned REC_DATA_W = 64;
    localparam int unsigned REC_REG_AW = 8;
    localparam int unsigned REC_MEM_AW = 16;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [REC_REG_AW-1:0] rd;
        logic [REC_MEM_AW-1:0] addr;
        logic [REC_DATA_W-1:0] result;
    } stage_rec_t;

    function automatic int unsigned shamt_w(input int unsigned data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/alu_pipe_exec.sv
// Combinational ALU for the execute stage; illegal codes give a zero
// result with the error flag set.
module alu_pipe_exec
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FUNC_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [FUNC_W-1:0] func,
    output logic [DATA_W-1:0] result_c,
    output logic              err_c
);

    localparam int unsigned SH_W = shamt_w(DATA_W);

    logic [SH_W-1:0] sh_amt;
    assign sh_amt = b[SH_W-1:0];

    always_comb begin
        result_c = '0;
        err_c    = 1'b0;
        case (4'(func))
            FN_ADD:   result_c = a + b;
            FN_SUB:   result_c = a - b;
            FN_MUL:   result_c = a * b;
            FN_PASSA: result_c = a;
            FN_PASSB: result_c = b;
            FN_AND:   result_c = a & b;
            FN_OR:    result_c = a | b;
            FN_XOR:   result_c = a ^ b;
            FN_NEGA:  result_c = -a;
            FN_NEGB:  result_c = -b;
            FN_SRL1:  result_c = a >> 1;
            FN_SHL1:  result_c = a << 1;
            FN_SRA1:  result_c = DATA_W'($signed(a) >>> 1);
            FN_SHL:   result_c = a << sh_amt;
            FN_SHR:   result_c = a >> sh_amt;
            default:  err_c    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe_param.sv
// Four-stage fetch/execute/writeback/memory pipeline with full forwarding,
// register-file preload port and a combinational debug read of data memory.
module alu_pipe_param
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned MEM_AW = 8,
    parameter int unsigned FUNC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [FUNC_W-1:0] func,
    input  logic [MEM_AW-1:0] addr,
    input  logic              cfg_we,
    input  logic [REG_AW-1:0] cfg_rd,
    input  logic [DATA_W-1:0] cfg_data,
    output logic [DATA_W-1:0] zout,
    output logic              out_valid,
    output logic              out_err,
    input  logic [MEM_AW-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned NUM_REGS  = 2 ** REG_AW;
    localparam int unsigned NUM_WORDS = 2 ** MEM_AW;

    if (FUNC_W != 4) begin : g_bad_func_w
        $error("alu_pipe_param: FUNC_W must be 4");
    end
    if (DATA_W < 8 || DATA_W > REC_DATA_W || REG_AW > REC_REG_AW || MEM_AW > REC_MEM_AW)
    begin : g_bad_width
        $error("alu_pipe_param: width parameter out of supported range");
    end

    logic [DATA_W-1:0] rf  [NUM_REGS];
    logic [DATA_W-1:0] mem [NUM_WORDS];

    logic              s1_valid;
    logic [REG_AW-1:0] s1_rd;
    logic [MEM_AW-1:0] s1_addr;
    logic [FUNC_W-1:0] s1_func;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;

    logic [DATA_W-1:0] ex_result_c;
    logic              ex_err_c;
    stage_rec_t        s2_next_c;
    stage_rec_t        s2;
    stage_rec_t        s3;

    logic [REG_AW-1:0] s2_rd_c;
    logic [DATA_W-1:0] s2_result_c;
    logic [MEM_AW-1:0] s3_addr_c;
    logic [DATA_W-1:0] s3_result_c;
    logic              s1_fwd_ok_c;
    logic              s2_fwd_ok_c;
    logic [DATA_W-1:0] fwd_a_c;
    logic [DATA_W-1:0] fwd_b_c;
    logic              unused_rec_bits;

    alu_pipe_exec #(
        .DATA_W (DATA_W),
        .FUNC_W (FUNC_W)
    ) u_exec (
        .a        (s1_a),
        .b        (s1_b),
        .func     (s1_func),
        .result_c (ex_result_c),
        .err_c    (ex_err_c)
    );

    assign s2_rd_c         = REG_AW'(s2.rd);
    assign s2_result_c     = DATA_W'(s2.result);
    assign s3_addr_c       = MEM_AW'(s3.addr);
    assign s3_result_c     = DATA_W'(s3.result);
    assign s1_fwd_ok_c     = s1_valid && !ex_err_c;
    assign s2_fwd_ok_c     = s2.valid && !s2.err;
    assign unused_rec_bits = ^{s2, s3};

    // Operand select: youngest producer first, then S2, then the register file.
    always_comb begin
        fwd_a_c = rf[rs1];
        fwd_b_c = rf[rs2];
        if (s2_fwd_ok_c && s2_rd_c == rs1) fwd_a_c = s2_result_c;
        if (s2_fwd_ok_c && s2_rd_c == rs2) fwd_b_c = s2_result_c;
        if (s1_fwd_ok_c && s1_rd == rs1)   fwd_a_c = ex_result_c;
        if (s1_fwd_ok_c && s1_rd == rs2)   fwd_b_c = ex_result_c;
    end

    // Bubbles carry a cleared record so they can never write or forward.
    always_comb begin
        s2_next_c        = '0;
        s2_next_c.valid  = s1_valid;
        s2_next_c.err    = s1_valid && ex_err_c;
        s2_next_c.rd     = REC_REG_AW'(s1_rd);
        s2_next_c.addr   = REC_MEM_AW'(s1_addr);
        s2_next_c.result = s1_valid ? REC_DATA_W'(ex_result_c) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_rd     <= '0;
            s1_addr   <= '0;
            s1_func   <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s2        <= '0;
            s3        <= '0;
            zout      <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s1_rd     <= rd;
            s1_addr   <= addr;
            s1_func   <= func;
            s1_a      <= fwd_a_c;
            s1_b      <= fwd_b_c;
            s2        <= s2_next_c;
            s3        <= s2;
            zout      <= s2_result_c;
            out_valid <= s2.valid;
            out_err   <= s2.valid && s2.err;
        end
    end

    // Writeback is ordered after preload so it wins on a same-register collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            if (cfg_we) rf[cfg_rd] <= cfg_data;
            if (s2_fwd_ok_c) rf[s2_rd_c] <= s2_result_c;
        end
    end

    always_ff @(posedge clk) begin
        if (s3.valid && !s3.err) mem[s3_addr_c] <= s3_result_c;
    end

    assign mem_rdata = mem[mem_raddr];

endmodule

// File: tb/tb_alu_pipe_param.sv
// Scoreboarded bench for alu_pipe_param: a program-order reference model
// predicts every result, a negedge monitor checks zout/out_err and latency.
module tb_alu_pipe_param;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        cfg_we;
    logic [3:0]  cfg_rd;
    logic [15:0] cfg_data;
    logic [15:0] zout;
    logic        out_valid;
    logic        out_err;
    logic [7:0]  mem_raddr;
    logic [15:0] mem_rdata;

    typedef struct {
        int          cyc;
        logic [15:0] z;
        logic        err;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] ref_rf  [16];
    logic [15:0] ref_mem [256];
    bit          ref_mem_ok [256];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    alu_pipe_param dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .func      (func),
        .addr      (addr),
        .cfg_we    (cfg_we),
        .cfg_rd    (cfg_rd),
        .cfg_data  (cfg_data),
        .zout      (zout),
        .out_valid (out_valid),
        .out_err   (out_err),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] ref_alu(input logic [3:0] f, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [31:0] p;
        logic [15:0] r;
        logic        e;
        e = 1'b0;
        r = 16'd0;
        p = 32'd0;
        case (f)
            4'd0:  r = a + b;
            4'd1:  r = a + (~b) + 16'd1;
            4'd2:  begin p = {16'd0, a} * {16'd0, b}; r = p[15:0]; end
            4'd3:  r = a;
            4'd4:  r = b;
            4'd5:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  r = a ^ b;
            4'd8:  r = 16'd0 - a;
            4'd9:  r = 16'd0 - b;
            4'd10: r = {1'b0, a[15:1]};
            4'd11: r = {a[14:0], 1'b0};
            4'd12: r = {a[15], a[15:1]};
            4'd13: r = a << b[3:0];
            4'd14: r = a >> b[3:0];
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    // Scoreboard monitor: every valid output must match the oldest prediction.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: out_valid=1 zout=%h err=%b at cycle %0d, required no output",
                         zout, out_err, cyc);
            end else begin
                mon_e = q.pop_front();
                if (zout !== mon_e.z || out_err !== mon_e.err || cyc !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL sb_result: zout=%h err=%b cycle=%0d, required zout=%h err=%b cycle=%0d",
                             zout, out_err, cyc, mon_e.z, mon_e.err, mon_e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] a_r, input logic [3:0] b_r, input logic [3:0] d_r,
                         input logic [3:0] f, input logic [7:0] ad, input bit track, input bit commit);
        logic [16:0] r;
        exp_t        e;
        r        = ref_alu(f, ref_rf[a_r], ref_rf[b_r]);
        rs1      = a_r;
        rs2      = b_r;
        rd       = d_r;
        func     = f;
        addr     = ad;
        in_valid = 1'b1;
        if (track) begin
            e.cyc = cyc + 3;
            e.z   = r[15:0];
            e.err = r[16];
            q.push_back(e);
        end
        if (commit && !r[16]) begin
            ref_rf[d_r]    = r[15:0];
            ref_mem[ad]    = r[15:0];
            ref_mem_ok[ad] = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic op(input logic [3:0] a_r, input logic [3:0] b_r, input logic [3:0] d_r,
                      input logic [3:0] f, input logic [7:0] ad);
        issue(a_r, b_r, d_r, f, ad, 1'b1, 1'b1);
    endtask

    task automatic preload(input logic [3:0] r, input logic [15:0] v);
        cfg_we   = 1'b1;
        cfg_rd   = r;
        cfg_data = v;
        @(negedge clk);
        cfg_we   = 1'b0;
        ref_rf[r] = v;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic peek(input logic [7:0] a, output logic [15:0] v);
        mem_raddr = a;
        #1;
        v = mem_rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0;
        cfg_we = 1'b0; cfg_rd = '0; cfg_data = '0; mem_raddr = '0;
        for (int i = 0; i < 16; i++) ref_rf[i] = 16'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (zout !== 16'd0 || out_valid !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: zout=%h valid=%b err=%b, required 0 0 0", zout, out_valid, out_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_valid: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_preload();
        for (int k = 0; k < 16; k++) preload(4'(k), 16'(k));
        for (int k = 0; k < 16; k++) op(4'(k), 4'd0, 4'(k), 4'd3, 8'd255);
        drain();
    endtask

    task automatic test_add();
        logic [15:0] v;
        op(4'd3, 4'd5, 4'd10, 4'd0, 8'd125);
        drain();
        @(negedge clk);
        peek(8'd125, v);
        checks++;
        if (v !== 16'd8) begin errors++; $display("FAIL add_mem125: got %h, required %h", v, 16'd8); end
        op(4'd10, 4'd0, 4'd10, 4'd3, 8'd255);
        drain();
        @(negedge clk);
        peek(8'd255, v);
        checks++;
        if (v !== 16'd8) begin errors++; $display("FAIL add_r10: got %h, required %h", v, 16'd8); end
    endtask

    task automatic test_forward();
        logic [15:0] v;
        // r10 is preloaded with a decoy so a stale read would give 45 instead of 3
        preload(4'd10, 16'd50);
        op(4'd3, 4'd5, 4'd10, 4'd0, 8'd125);
        op(4'd10, 4'd5, 4'd14, 4'd1, 8'd125);
        drain();
        preload(4'd10, 16'd50);
        op(4'd3, 4'd5, 4'd10, 4'd0, 8'd125);
        @(negedge clk);
        op(4'd10, 4'd5, 4'd14, 4'd1, 8'd125);
        drain();
        preload(4'd10, 16'd50);
        op(4'd3, 4'd5, 4'd10, 4'd0, 8'd125);
        repeat (2) @(negedge clk);
        op(4'd10, 4'd5, 4'd14, 4'd1, 8'd125);
        drain();
        @(negedge clk);
        peek(8'd125, v);
        checks++;
        if (v !== 16'd3) begin errors++; $display("FAIL fwd_mem125: got %h, required %h", v, 16'd3); end
    endtask

    task automatic test_funcs();
        logic [15:0] v;
        op(4'd3, 4'd8, 4'd12, 4'd2, 8'd126);
        preload(4'd1, 16'hFFFF);
        op(4'd1, 4'd1, 4'd15, 4'd0, 8'd120);
        preload(4'd2, 16'h8000);
        op(4'd2, 4'd0, 4'd11, 4'd12, 8'd121);
        op(4'd7, 4'd3, 4'd6, 4'd13, 8'd122);
        drain();
        @(negedge clk);
        peek(8'd126, v);
        checks++;
        if (v !== 16'd24) begin errors++; $display("FAIL mul_mem126: got %h, required %h", v, 16'd24); end
        peek(8'd120, v);
        checks++;
        if (v !== 16'hFFFE) begin errors++; $display("FAIL wrap_add: got %h, required %h", v, 16'hFFFE); end
        peek(8'd121, v);
        checks++;
        if (v !== 16'hC000) begin errors++; $display("FAIL sra: got %h, required %h", v, 16'hC000); end
        peek(8'd122, v);
        checks++;
        if (v !== 16'd56) begin errors++; $display("FAIL shl_var: got %h, required %h", v, 16'd56); end
        preload(4'd4, 16'hA5C3);
        for (int f = 0; f < 15; f++) op(4'd4, 4'd5, 4'd8, 4'(f), 8'd123);
        drain();
    endtask

    task automatic test_mem_and_illegal();
        logic [15:0] v;
        op(4'd9, 4'd0, 4'd9, 4'd3, 8'd127);
        drain();
        @(negedge clk);
        peek(8'd127, v);
        checks++;
        if (v !== 16'd9) begin errors++; $display("FAIL mem127_init: got %h, required %h", v, 16'd9); end
        op(4'd7, 4'd0, 4'd7, 4'd3, 8'd127);
        repeat (2) @(negedge clk);
        peek(8'd127, v);
        checks++;
        if (v !== 16'd9) begin errors++; $display("FAIL mem_old_value: got %h, required %h", v, 16'd9); end
        @(negedge clk);
        peek(8'd127, v);
        checks++;
        if (v !== 16'd7) begin errors++; $display("FAIL mem_new_value: got %h, required %h", v, 16'd7); end
        op(4'd0, 4'd0, 4'd13, 4'd15, 8'd127);
        op(4'd13, 4'd0, 4'd11, 4'd0, 8'd119);
        drain();
        @(negedge clk);
        peek(8'd127, v);
        checks++;
        if (v !== 16'd7) begin errors++; $display("FAIL illegal_mem: got %h, required %h", v, 16'd7); end
        peek(8'd119, v);
        checks++;
        if (v !== 16'd13) begin errors++; $display("FAIL illegal_r13: got %h, required %h", v, 16'd13); end
    endtask

    task automatic test_preload_collision();
        logic [15:0] v;
        op(4'd3, 4'd5, 4'd10, 4'd0, 8'd125);
        @(negedge clk);
        cfg_we = 1'b1; cfg_rd = 4'd10; cfg_data = 16'd99;
        @(negedge clk);
        cfg_we = 1'b0;
        ref_rf[10] = 16'd8;
        drain();
        op(4'd10, 4'd0, 4'd10, 4'd3, 8'd255);
        drain();
        @(negedge clk);
        peek(8'd255, v);
        checks++;
        if (v !== 16'd8) begin errors++; $display("FAIL collide_same_edge: got %h, required %h", v, 16'd8); end
        op(4'd3, 4'd5, 4'd10, 4'd0, 8'd125);
        repeat (2) @(negedge clk);
        cfg_we = 1'b1; cfg_rd = 4'd10; cfg_data = 16'd99;
        @(negedge clk);
        cfg_we = 1'b0;
        ref_rf[10] = 16'd99;
        drain();
        op(4'd10, 4'd0, 4'd10, 4'd3, 8'd255);
        drain();
        @(negedge clk);
        peek(8'd255, v);
        checks++;
        if (v !== 16'd99) begin errors++; $display("FAIL collide_later: got %h, required %h", v, 16'd99); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 8'($urandom_range(0, 63)));
        end
        drain();
        @(negedge clk);
        for (int a = 0; a < 64; a++) begin
            if (ref_mem_ok[a]) begin
                peek(8'(a), v);
                checks++;
                if (v !== ref_mem[a]) begin
                    errors++;
                    $display("FAIL b2b_mem[%0d]: got %h, required %h", a, v, ref_mem[a]);
                end
            end
        end
        for (int k = 0; k < 16; k++) op(4'(k), 4'd0, 4'(k), 4'd3, 8'd255);
        drain();
    endtask

    task automatic test_reset_inflight();
        logic [15:0] v;
        preload(4'd4, 16'h1111);
        for (int a = 200; a < 203; a++) op(4'd4, 4'd4, 4'd4, 4'd3, 8'(a));
        drain();
        @(negedge clk);
        preload(4'd5, 16'h2222);
        issue(4'd5, 4'd5, 4'd4, 4'd0, 8'd200, 1'b1, 1'b0);
        issue(4'd5, 4'd5, 4'd5, 4'd3, 8'd201, 1'b0, 1'b0);
        issue(4'd5, 4'd5, 4'd6, 4'd0, 8'd202, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || zout !== 16'h4444) begin
            errors++;
            $display("FAIL inflight_before_reset: valid=%b zout=%h, required 1 4444", out_valid, zout);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (zout !== 16'd0 || out_valid !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL inflight_reset_outputs: zout=%h valid=%b err=%b, required 0 0 0",
                     zout, out_valid, out_err);
        end
        for (int i = 0; i < 16; i++) ref_rf[i] = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_valid: out_valid=%b, required 0", out_valid);
            end
        end
        for (int a = 200; a < 203; a++) begin
            peek(8'(a), v);
            checks++;
            if (v !== 16'h1111) begin
                errors++;
                $display("FAIL post_reset_mem[%0d]: got %h, required %h", a, v, 16'h1111);
            end
        end
        op(4'd4, 4'd0, 4'd9, 4'd3, 8'd255);
        op(4'd5, 4'd6, 4'd6, 4'd0, 8'd203);
        drain();
    endtask

    initial begin
        test_reset();
        test_preload();
        test_add();
        test_forward();
        test_funcs();
        test_mem_and_illegal();
        test_preload_collision();
        test_back_to_back();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_pipe_param.md
Name: alu_pipe_param

Overview:
Parametrised single-clock successor to the team's two-phase 4-stage register/ALU/memory pipeline. Each accepted instruction flows through four stages: operand fetch, execute, register writeback, memory write. The block adds a valid bit per stage, full operand forwarding, an extended function set, error flagging, a preload port for the register file, and a debug read port on the data memory. It is the compute core that sits between the instruction source and the data memory.

Parameters:
DATA_W, 16, datapath, register and memory word width (min 8)
REG_AW, 4, register-file address width; 2**REG_AW registers
MEM_AW, 8, data-memory address width; 2**MEM_AW words
FUNC_W, 4, function-code width (fixed 4; asserted at elaboration)

Ports:
clk  in  1  single clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction present this cycle; no backpressure, always accepted
rs1  in  REG_AW  source register A
rs2  in  REG_AW  source register B
rd  in  REG_AW  destination register
func  in  FUNC_W  operation code
addr  in  MEM_AW  memory write address for the result
cfg_we  in  1  register-file preload strobe
cfg_rd  in  REG_AW  preload register index
cfg_data  in  DATA_W  preload value
zout  out  DATA_W  stage-3 result register
out_valid  out  1  zout holds a valid result
out_err  out  1  zout instruction had an illegal func
mem_raddr  in  MEM_AW  debug read address
mem_rdata  out  DATA_W  combinational mem[mem_raddr]

Behaviour:
- Reset (async assert, sync deassert): all stage valid bits 0; zout 0; out_valid 0; out_err 0; all registers 0. Memory is not reset. In-flight instructions are discarded, and no memory or register write occurs for them after release.
- Timing for an instruction accepted at edge N (in_valid=1):
  - Edge N (S1): operands captured, with forwarding applied.
  - Edge N+1 (S2): ALU result registered.
  - Edge N+2 (S3): regfile[rd] written; zout, out_valid and out_err updated.
  - Edge N+3 (S4): mem[addr] written.
- Latency: input to zout is 3 edges.
- in_valid=0 inserts a bubble. A bubble performs no writes; out_valid=0 in its S3 cycle.
- Forwarding priority for each operand at edge N:
  1. Combinational ALU output of the instruction in S1, if valid, not err, and rd matches.
  2. The S2 result, if valid, not err, and rd matches.
  3. The register file.
- Dependent back-to-back instructions therefore never stall and never see stale data.
- Function codes, with a=opA and b=opB; results truncated to DATA_W, two's-complement wrap, no flags:
  - 0 a+b; 1 a-b; 2 low DATA_W bits of a*b; 3 a; 4 b
  - 5 a&b; 6 a|b; 7 a^b; 8 -a; 9 -b
  - 10 a>>1 logical; 11 a<<1; 12 a>>>1 arithmetic
  - 13 a<<b[$clog2(DATA_W)-1:0]; 14 a>>b[$clog2(DATA_W)-1:0] logical
  - 15 illegal
- Illegal func: result forced to 0 and err bit carried with the instruction. At S3, out_valid=1, out_err=1, zout=0. No register write, no memory write, and the instruction is never used as a forwarding source.
- Preload: cfg_we writes regfile[cfg_rd]=cfg_data at the edge. If the S3 writeback targets the same register at the same edge, the S3 writeback wins. Preload does not feed the forwarding network.
- Debug read: mem_rdata reflects contents before the current edge. Reading the address being written at edge K returns the old value until after K.
- rd and addr are unconstrained. A write to the same address by consecutive instructions leaves the last one's value.

Decomposition:
- Package alu_pipe_pkg holds:
  - func code localparams (FN_ADD..FN_SHR, FN_ILLEGAL);
  - a stage-record struct (valid, err, rd, addr, result);
  - a function that returns shift width from DATA_W.
- One sub-module, alu_pipe_exec: purely combinational ALU (a, b, func → result, err).
- Forwarding mux, regfile and memory stay in the top module.

Test Plan:
- Preload r[k]=k for k=0..15. Issue add r3+r5→r10, addr=125 at edge N → zout=8, out_valid=1 after N+2; regfile r10=8; mem[125]=8 after N+3.
- Issue sub r10-r5→r14 one cycle after the add above (S1 forward) → zout=3; repeat with one bubble between (S2 forward) → zout=3.
- mul r3*r8→r12, addr=126 → zout=24; set r1=16'hFFFF, add r1+r1 → zout=16'hFFFE; sra on 16'h8000 → 16'hC000; shl r7 by r3 → 56.
- func=15 with rd=13, addr=127 → out_valid=1, out_err=1, zout=0; r13 stays 13; mem[127] unchanged; a following add using r13 reads 13.
- cfg_we to r10 with data 99 at the same edge as S3 writes r10=8 → r10=8. cfg_we to r10 with data 99 one cycle later → r10=99.
- Assert rst_n low while 3 instructions are in flight → outputs 0 immediately. After release, none of their mem[] or regfile writes occur and out_valid stays 0 until a new instruction reaches S3.
